lmb_bram_if_ctrl: RTL and testbench

LMB slave controller that sits directly upstream of the dual-port LMB BRAM array, one instance per BRAM port (instruction side on A, data side on B). It decodes LMB bus requests against its address window, drives the BRAM port enable, byte write-enables, address and write data, and returns read data with an LMB ready handshake. It also keeps per-port read/write access counters and a sticky protocol-error flag for debug.

---
 rtl/lmb_bram_if_ctrl_if.sv | 41 ++++
 rtl/lmb_bram_if_ctrl.sv | 126 ++++++++++++
 tb/tb_lmb_bram_if_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lmb_bram_if_ctrl_if.sv
// ============================================================================
// lmb_bram_if_ctrl_if : LMB request/response bus and BRAM port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface lmb_bram_if_ctrl_if #(
  parameter int C_LMB_AWIDTH = 32,
  parameter int C_LMB_DWIDTH = 32,
  parameter int C_NUM_WE     = 4
) ();
  logic [0:C_LMB_AWIDTH-1] LMB_ABus;
  logic                    LMB_AddrStrobe;
  logic                    LMB_ReadStrobe;
  logic                    LMB_WriteStrobe;
  logic [0:C_NUM_WE-1]     LMB_BE;
  logic [0:C_LMB_DWIDTH-1] LMB_WriteDBus;
  logic [0:C_LMB_DWIDTH-1] Sl_DBus;
  logic                    Sl_Ready;
  logic                    BRAM_EN;
  logic [0:C_NUM_WE-1]     BRAM_WEN;
  logic [0:C_LMB_AWIDTH-1] BRAM_Addr;
  logic [0:C_LMB_DWIDTH-1] BRAM_Dout;
  logic [0:C_LMB_DWIDTH-1] BRAM_Din;

  // Controller side: consumes LMB requests and BRAM read data.
  modport slave (
    input  LMB_ABus, LMB_AddrStrobe, LMB_ReadStrobe, LMB_WriteStrobe,
    input  LMB_BE, LMB_WriteDBus, BRAM_Din,
    output Sl_DBus, Sl_Ready, BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
  );

  // Bus master / BRAM side.
  modport master (
    output LMB_ABus, LMB_AddrStrobe, LMB_ReadStrobe, LMB_WriteStrobe,
    output LMB_BE, LMB_WriteDBus, BRAM_Din,
    input  Sl_DBus, Sl_Ready, BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
  );
endinterface

`default_nettype wire

// File: rtl/lmb_bram_if_ctrl.sv
// ============================================================================
// lmb_bram_if_ctrl : LMB slave in front of one BRAM port, with access counters
// Rev 1.0
// ============================================================================
`default_nettype none

module lmb_bram_if_ctrl #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_3FFF,
  parameter int          C_LMB_AWIDTH = 32,
  parameter int          C_LMB_DWIDTH = 32,
  parameter int          C_NUM_WE     = 4,
  parameter int          C_REG_RDATA  = 0
) (
  input  logic                  LMB_Clk,
  input  logic                  LMB_Rst_N,
  lmb_bram_if_ctrl_if.slave     lmb,
  input  logic                  Cnt_Clr,
  output logic [15:0]           Rd_Count,
  output logic [15:0]           Wr_Count,
  output logic                  Proto_Err
);

  localparam logic [C_LMB_AWIDTH-1:0] WIN_MASK  = C_LMB_AWIDTH'(C_HIGHADDR - C_BASEADDR);
  localparam logic [C_LMB_AWIDTH-1:0] BASE      = C_LMB_AWIDTH'(C_BASEADDR);
  localparam logic [C_LMB_AWIDTH-1:0] ADDR_MASK = WIN_MASK & ~(C_LMB_AWIDTH'(3));
  localparam bit                      REG_RD    = (C_REG_RDATA != 0);
  localparam logic [15:0]             CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    resp_read;
  logic [0:C_LMB_DWIDTH-1] capt_data;

  logic hit;
  logic qual;
  logic can_accept;
  logic accept;
  logic is_write;
  logic is_read;
  logic err_set;

  // Request decode. A strobe with both qualifiers is treated as a write.
  always_comb begin
    hit        = ((lmb.LMB_ABus & ~WIN_MASK) == BASE);
    qual       = lmb.LMB_ReadStrobe | lmb.LMB_WriteStrobe;
    can_accept = !REG_RD || (state == IDLE);
    accept     = lmb.LMB_AddrStrobe & hit & qual & can_accept;
    is_write   = lmb.LMB_WriteStrobe;
    is_read    = lmb.LMB_ReadStrobe & ~lmb.LMB_WriteStrobe;
    err_set    = lmb.LMB_AddrStrobe &
                 (~can_accept |
                  (hit & can_accept & ~qual) |
                  (accept & lmb.LMB_ReadStrobe & lmb.LMB_WriteStrobe));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = REG_RD ? CAPT : RESP;
      CAPT:    next_state = RESP;
      RESP:    next_state = (accept && !REG_RD) ? RESP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge LMB_Clk or negedge LMB_Rst_N) begin
    if (!LMB_Rst_N) begin
      state     <= IDLE;
      resp_read <= 1'b0;
      capt_data <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        resp_read <= is_read;
      end
      if (state == CAPT) begin
        capt_data <= resp_read ? lmb.BRAM_Din : '0;
      end
    end
  end

  // Counters saturate; a clear wins over a same-cycle increment.
  always_ff @(posedge LMB_Clk or negedge LMB_Rst_N) begin
    if (!LMB_Rst_N) begin
      Rd_Count  <= '0;
      Wr_Count  <= '0;
      Proto_Err <= 1'b0;
    end else begin
      if (Cnt_Clr) begin
        Rd_Count <= '0;
        Wr_Count <= '0;
      end else begin
        if (accept && is_read && (Rd_Count != CNT_MAX)) begin
          Rd_Count <= Rd_Count + 16'd1;
        end
        if (accept && is_write && (Wr_Count != CNT_MAX)) begin
          Wr_Count <= Wr_Count + 16'd1;
        end
      end
      if (err_set) begin
        Proto_Err <= 1'b1;
      end
    end
  end

  assign lmb.BRAM_EN   = accept;
  assign lmb.BRAM_WEN  = (accept && is_write) ? lmb.LMB_BE : '0;
  assign lmb.BRAM_Addr = lmb.LMB_ABus & ADDR_MASK;
  assign lmb.BRAM_Dout = lmb.LMB_WriteDBus;

  // Sl_DBus is zero outside a response so several slaves can share an OR-bus.
  assign lmb.Sl_Ready = (state == RESP);
  assign lmb.Sl_DBus  = (state != RESP) ? '0 :
                        REG_RD          ? capt_data :
                        resp_read       ? lmb.BRAM_Din : '0;

endmodule

`default_nettype wire

// File: tb/tb_lmb_bram_if_ctrl.sv
// ============================================================================
// tb_lmb_bram_if_ctrl : directed bench for both response modes of the controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lmb_bram_if_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_clr;
  logic [15:0] rd0, wr0, rd1, wr1;
  logic        perr0, perr1;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [0:31] mem0 [0:4095];
  logic [0:31] mem1 [0:4095];

  always #5 clk = ~clk;

  lmb_bram_if_ctrl_if b0 ();
  lmb_bram_if_ctrl_if b1 ();

  lmb_bram_if_ctrl #(.C_REG_RDATA(0)) dut0 (
    .LMB_Clk(clk), .LMB_Rst_N(rst_n), .lmb(b0), .Cnt_Clr(cnt_clr),
    .Rd_Count(rd0), .Wr_Count(wr0), .Proto_Err(perr0)
  );

  lmb_bram_if_ctrl #(.C_REG_RDATA(1)) dut1 (
    .LMB_Clk(clk), .LMB_Rst_N(rst_n), .lmb(b1), .Cnt_Clr(cnt_clr),
    .Rd_Count(rd1), .Wr_Count(wr1), .Proto_Err(perr1)
  );

  // Behavioural BRAMs: registered read-before-write, byte lanes big-endian.
  always @(posedge clk) begin
    if (b0.BRAM_EN) begin
      for (int i = 0; i < 4; i++)
        if (b0.BRAM_WEN[i]) mem0[b0.BRAM_Addr[18:29]][i*8 +: 8] <= b0.BRAM_Dout[i*8 +: 8];
      b0.BRAM_Din <= mem0[b0.BRAM_Addr[18:29]];
    end
  end

  always @(posedge clk) begin
    if (b1.BRAM_EN) begin
      for (int i = 0; i < 4; i++)
        if (b1.BRAM_WEN[i]) mem1[b1.BRAM_Addr[18:29]][i*8 +: 8] <= b1.BRAM_Dout[i*8 +: 8];
      b1.BRAM_Din <= mem1[b1.BRAM_Addr[18:29]];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic as, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    b0.LMB_AddrStrobe  = as;
    b0.LMB_ReadStrobe  = rd;
    b0.LMB_WriteStrobe = wr;
    b0.LMB_ABus        = a;
    b0.LMB_BE          = be;
    b0.LMB_WriteDBus   = d;
  endtask

  task automatic drv1(input logic as, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    b1.LMB_AddrStrobe  = as;
    b1.LMB_ReadStrobe  = rd;
    b1.LMB_WriteStrobe = wr;
    b1.LMB_ABus        = a;
    b1.LMB_BE          = be;
    b1.LMB_WriteDBus   = d;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    drv1(0, 0, 0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready0", b0.Sl_Ready, 1'b0);
    check_eq("rst_dbus0",  b0.Sl_DBus,  32'h0);
    check_eq("rst_rd0",    rd0,         16'h0);
    check_eq("rst_wr0",    wr0,         16'h0);
    check_eq("rst_perr0",  perr0,       1'b0);
    check_eq("rst_ready1", b1.Sl_Ready, 1'b0);
    check_eq("rst_perr1",  perr1,       1'b0);
    @(negedge clk) rst_n = 1'b1;

    // ---- registered-read mode ----
    @(negedge clk) drv1(1, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    check_eq("m1_wr_en",  b1.BRAM_EN,  1'b1);
    check_eq("m1_wr_wen", b1.BRAM_WEN, 4'hF);
    @(negedge clk) drv1(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1 check_eq("m1_wr_capt_ready", b1.Sl_Ready, 1'b0);
    @(negedge clk) #1;
    check_eq("m1_wr_ready", b1.Sl_Ready, 1'b1);
    check_eq("m1_wr_dbus",  b1.Sl_DBus,  32'h0);
    check_eq("m1_wr_cnt",   wr1,         16'd1);
    @(negedge clk) drv1(1, 1, 0, 32'h10, 4'hF, 32'h0);
    #1;
    check_eq("m1_rd_en",  b1.BRAM_EN,  1'b1);
    check_eq("m1_rd_wen", b1.BRAM_WEN, 4'h0);
    @(negedge clk) drv1(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1 check_eq("m1_rd_capt_ready", b1.Sl_Ready, 1'b0);
    @(negedge clk) #1;
    check_eq("m1_rd_ready", b1.Sl_Ready, 1'b1);
    check_eq("m1_rd_dbus",  b1.Sl_DBus,  32'hDEADBEEF);
    check_eq("m1_rd_cnt",   rd1,         16'd1);
    check_eq("m1_perr_pre", perr1,       1'b0);
    @(negedge clk) drv1(1, 1, 0, 32'h10, 4'hF, 32'h0);
    @(negedge clk) drv1(1, 1, 0, 32'h14, 4'hF, 32'h0);
    #1;
    check_eq("m1_busy_en",    b1.BRAM_EN,  1'b0);
    check_eq("m1_busy_ready", b1.Sl_Ready, 1'b0);
    @(negedge clk) drv1(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    check_eq("m1_busy_resp", b1.Sl_Ready, 1'b1);
    check_eq("m1_busy_dbus", b1.Sl_DBus,  32'hDEADBEEF);
    check_eq("m1_busy_perr", perr1,       1'b1);
    check_eq("m1_busy_cnt",  rd1,         16'd2);
    @(negedge clk) #1 check_eq("m1_busy_idle", b1.Sl_Ready, 1'b0);

    // ---- combinational-read mode ----
    @(negedge clk) drv0(1, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    check_eq("wr_en",   b0.BRAM_EN,   1'b1);
    check_eq("wr_wen",  b0.BRAM_WEN,  4'hF);
    check_eq("wr_addr", b0.BRAM_Addr, 32'h10);
    check_eq("wr_dout", b0.BRAM_Dout, 32'hDEADBEEF);
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    check_eq("wr_ready", b0.Sl_Ready, 1'b1);
    check_eq("wr_dbus",  b0.Sl_DBus,  32'h0);
    check_eq("wr_cnt",   wr0,         16'd1);
    @(negedge clk) drv0(1, 1, 0, 32'h10, 4'hF, 32'h0);
    #1;
    check_eq("rd_en",  b0.BRAM_EN,  1'b1);
    check_eq("rd_wen", b0.BRAM_WEN, 4'h0);
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    check_eq("rd_ready", b0.Sl_Ready, 1'b1);
    check_eq("rd_dbus",  b0.Sl_DBus,  32'hDEADBEEF);
    check_eq("rd_cnt",   rd0,         16'd1);
    @(negedge clk) #1;
    check_eq("rd_idle_ready", b0.Sl_Ready, 1'b0);
    check_eq("rd_idle_dbus",  b0.Sl_DBus,  32'h0);

    // Top word of the window, byte lane 1 only, then one past the window.
    @(negedge clk) drv0(1, 0, 1, 32'h3FFC, 4'hF, 32'h0);
    @(negedge clk) drv0(1, 0, 1, 32'h3FFC, 4'b0100, 32'h11223344);
    #1;
    check_eq("bw_wen",  b0.BRAM_WEN,  4'b0100);
    check_eq("bw_addr", b0.BRAM_Addr, 32'h3FFC);
    @(negedge clk) drv0(1, 1, 0, 32'h3FFC, 4'hF, 32'h0);
    @(negedge clk) drv0(1, 1, 0, 32'h4000, 4'hF, 32'h0);
    #1;
    check_eq("miss_en",  b0.BRAM_EN,  1'b0);
    check_eq("bw_ready", b0.Sl_Ready, 1'b1);
    check_eq("bw_dbus",  b0.Sl_DBus,  32'h0022_0000);
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    check_eq("miss_ready", b0.Sl_Ready, 1'b0);
    check_eq("miss_perr",  perr0,       1'b0);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk) drv0(1, 0, 1, 32'h20 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) drv0(1, 1, 0, 32'h20 + 32'(4 * k), 4'hF, 32'h0);
      #1;
      check_eq($sformatf("b2b_ready%0d", k), b0.Sl_Ready, 1'b1);
      check_eq($sformatf("b2b_dbus%0d", k), b0.Sl_DBus,
               (k == 0) ? 32'h0 : 32'hA000_0000 + 32'(k - 1));
    end
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    check_eq("b2b_ready4", b0.Sl_Ready, 1'b1);
    check_eq("b2b_dbus4",  b0.Sl_DBus,  32'hA000_0003);
    @(negedge clk) #1;
    check_eq("b2b_end", b0.Sl_Ready, 1'b0);
    check_eq("b2b_wr",  wr0,         16'd7);
    check_eq("b2b_rd",  rd0,         16'd6);

    // Strobe without qualifier.
    @(negedge clk) drv0(1, 0, 0, 32'h10, 4'hF, 32'h0);
    #1 check_eq("noq_en", b0.BRAM_EN, 1'b0);
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    check_eq("noq_ready", b0.Sl_Ready, 1'b0);
    check_eq("noq_perr",  perr0,       1'b1);
    check_eq("noq_wr",    wr0,         16'd7);

    // Clear beats increment, then saturation.
    @(negedge clk) begin cnt_clr = 1'b1; drv0(1, 0, 1, 32'h40, 4'hF, 32'h1); end
    @(negedge clk) begin cnt_clr = 1'b0; drv0(0, 0, 0, 32'h0, 4'h0, 32'h0); end
    #1;
    check_eq("clr_wr", wr0, 16'h0);
    check_eq("clr_rd", rd0, 16'h0);
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk) drv0(1, 0, 1, 32'h40, 4'hF, 32'(i));
    end
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1 check_eq("sat_fffe", wr0, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) drv0(1, 0, 1, 32'h40, 4'hF, 32'(i));
    end
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1 check_eq("sat_ffff", wr0, 16'hFFFF);
    @(negedge clk) begin cnt_clr = 1'b1; drv0(1, 0, 1, 32'h40, 4'hF, 32'h0); end
    @(negedge clk) begin cnt_clr = 1'b0; drv0(0, 0, 0, 32'h0, 4'h0, 32'h0); end
    #1 check_eq("sat_clr", wr0, 16'h0);

    // Reset right after an accepted read.
    @(negedge clk) drv0(1, 1, 0, 32'h10, 4'hF, 32'h0);
    @(posedge clk);
    #1 begin rst_n = 1'b0; drv0(0, 0, 0, 32'h0, 4'h0, 32'h0); end
    @(negedge clk) #1;
    check_eq("mid_rst_ready", b0.Sl_Ready, 1'b0);
    check_eq("mid_rst_dbus",  b0.Sl_DBus,  32'h0);
    check_eq("mid_rst_en",    b0.BRAM_EN,  1'b0);
    check_eq("mid_rst_rd",    rd0,         16'h0);
    check_eq("mid_rst_perr0", perr0,       1'b0);
    check_eq("mid_rst_perr1", perr1,       1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) #1 check_eq("post_rst_noready", b0.Sl_Ready, 1'b0);
    @(negedge clk) drv0(1, 1, 0, 32'h10, 4'hF, 32'h0);
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    check_eq("post_rst_ready", b0.Sl_Ready, 1'b1);
    check_eq("post_rst_dbus",  b0.Sl_DBus,  32'hDEADBEEF);
    check_eq("post_rst_rd",    rd0,         16'd1);

    // Read and write qualifiers together: performed as a write.
    @(negedge clk) drv0(1, 1, 1, 32'h50, 4'hF, 32'h1234_5678);
    #1;
    check_eq("both_en",  b0.BRAM_EN,  1'b1);
    check_eq("both_wen", b0.BRAM_WEN, 4'hF);
    @(negedge clk) drv0(0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    check_eq("both_ready", b0.Sl_Ready, 1'b1);
    check_eq("both_dbus",  b0.Sl_DBus,  32'h0);
    check_eq("both_perr",  perr0,       1'b1);
    check_eq("both_wr",    wr0,         16'd1);
    check_eq("both_rd",    rd0,         16'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
